// File: rtl/fsm.sv
// Start-triggered sequencer: IDLE -> RUN (RUN_CYCLES) -> DONE (DONE_HOLD) -> IDLE.
// Moore machine; flag_done/busy are registered from the next-state value.
module fsm #(
    parameter int RUN_CYCLES = 4,
    parameter int DONE_HOLD  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       flag_done,
    output logic       busy,
    output logic [1:0] state
);

    generate
        if (RUN_CYCLES < 1) begin : g_bad_run
            $error("fsm: RUN_CYCLES must be >= 1");
        end
        if (DONE_HOLD < 1) begin : g_bad_hold
            $error("fsm: DONE_HOLD must be >= 1");
        end
    endgenerate

    localparam int CNT_MAX = (RUN_CYCLES > DONE_HOLD) ? RUN_CYCLES : DONE_HOLD;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] RUN_LAST  = CW'(RUN_CYCLES - 1);
    localparam logic [CW-1:0] DONE_LAST = CW'(DONE_HOLD - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_DONE    = 2'd2,
        ST_ILLEGAL = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            flag_done_q, flag_done_d;
    logic            busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (cnt_q == RUN_LAST) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (cnt_q == DONE_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output flops track the state the register is about to hold, so a stray
    // encoding 2'd3 is decoded as all-zero outputs.
    always_comb begin
        flag_done_d = (state_d == ST_DONE);
        busy_d      = (state_d == ST_RUN) || (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            flag_done_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            flag_done_q <= flag_done_d;
            busy_q      <= busy_d;
        end
    end

    assign flag_done = flag_done_q;
    assign busy      = busy_q;
    assign state     = state_q;

endmodule

// File: tb/tb_fsm.sv
// Bench for fsm: three parameterisations side by side, checked every cycle
// against a timeline model derived from the start-to-flag_done latency rules.
module tb_fsm;

    logic       clk;
    logic       rst;
    logic [2:0] start_v;
    logic [2:0] flag_v;
    logic [2:0] busy_v;
    logic [1:0] state_v [3];

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;

    // Per-instance parameters: defaults, short run / long hold, long run.
    int run_p  [3] = '{4, 1, 7};
    int hold_p [3] = '{1, 3, 1};

    // Model: an active run is fully described by the edge index where start was taken.
    bit act   [3] = '{0, 0, 0};
    int k_edge[3] = '{0, 0, 0};

    fsm #(.RUN_CYCLES(4), .DONE_HOLD(1)) u_dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]),
        .flag_done(flag_v[0]), .busy(busy_v[0]), .state(state_v[0])
    );
    fsm #(.RUN_CYCLES(1), .DONE_HOLD(3)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]),
        .flag_done(flag_v[1]), .busy(busy_v[1]), .state(state_v[1])
    );
    fsm #(.RUN_CYCLES(7), .DONE_HOLD(1)) u_dut2 (
        .clk(clk), .rst(rst), .start(start_v[2]),
        .flag_done(flag_v[2]), .busy(busy_v[2]), .state(state_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int idx, input logic [1:0] obs,
                         input logic [1:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s dut%0d edge=%0d observed=%0d expected=%0d",
                    tag, idx, cyc, obs, exp);
    endtask

    task automatic tick(input logic r, input logic [2:0] s);
        int e;
        logic [1:0] exp_state;
        logic       exp_flag, exp_busy;
        rst     = r;
        start_v = s;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (r) begin
                act[i] = 0;
            end else if (!act[i]) begin
                if (s[i]) begin
                    act[i]    = 1;
                    k_edge[i] = cyc;
                end
            end else if (cyc == k_edge[i] + run_p[i] + hold_p[i]) begin
                act[i] = 0;
            end
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            exp_state = 2'd0;
            exp_flag  = 1'b0;
            exp_busy  = 1'b0;
            if (act[i]) begin
                e         = cyc - k_edge[i];
                exp_busy  = 1'b1;
                exp_flag  = (e >= run_p[i]);
                exp_state = exp_flag ? 2'd2 : 2'd1;
            end
            check("state", i, state_v[i], exp_state);
            check("flag_done", i, {1'b0, flag_v[i]}, {1'b0, exp_flag});
            check("busy", i, {1'b0, busy_v[i]}, {1'b0, exp_busy});
        end
        $display("edge %0d rst=%b start=%b state=%0d/%0d/%0d flag=%b busy=%b",
                 cyc, r, s, state_v[0], state_v[1], state_v[2], flag_v, busy_v);
        cyc++;
    endtask

    initial begin
        rst     = 1'b1;
        start_v = 3'b000;

        // Reset held two cycles with start asserted.
        tick(1'b1, 3'b111);
        tick(1'b1, 3'b111);

        // Single run.
        tick(1'b0, 3'b111);
        for (int i = 0; i < 10; i++) tick(1'b0, 3'b000);

        // Start pulses during RUN (k+2) and DONE (k+4) are ignored.
        tick(1'b0, 3'b111);
        tick(1'b0, 3'b000);
        tick(1'b0, 3'b111);
        tick(1'b0, 3'b000);
        tick(1'b0, 3'b111);
        for (int i = 0; i < 10; i++) tick(1'b0, 3'b000);

        // Held start: back-to-back runs with a single IDLE gap.
        for (int i = 0; i < 20; i++) tick(1'b0, 3'b111);
        tick(1'b1, 3'b000);

        // Reset at edge k+3 aborts the run.
        tick(1'b0, 3'b111);
        tick(1'b0, 3'b000);
        tick(1'b0, 3'b000);
        tick(1'b1, 3'b000);
        for (int i = 0; i < 8; i++) tick(1'b0, 3'b000);

        // Random traffic with occasional resets.
        for (int i = 0; i < 300; i++) begin
            logic [2:0] s;
            logic       r;
            s[0] = ($urandom_range(0, 99) < 30);
            s[1] = ($urandom_range(0, 99) < 30);
            s[2] = ($urandom_range(0, 99) < 30);
            r    = ($urandom_range(0, 99) < 3);
            tick(r, s);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
